// File: rtl/syn_timer_multi.sv
// Multi-channel Avalon-MM interval timer: 2**CH_AW programmable down-counters sharing one
// prescaler, one registered read port, a combined irq line and a per-channel tick vector.
module syn_timer_multi #(
  parameter int CH_AW      = 2,
  parameter int CNT_W      = 32,
  parameter int DEF_PERIOD = 99,
  parameter int PRESCALE   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CH_AW+2:0]    address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [15:0]         writedata,
  output logic [15:0]         readdata,
  output logic                irq,
  output logic [2**CH_AW-1:0] irq_vec,
  output logic [2**CH_AW-1:0] tick
);
  localparam int NUM_CH = 2**CH_AW;
  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LO_W   = (CNT_W < 16) ? CNT_W : 16;

  typedef enum logic [2:0] {
    OFF_STATUS  = 3'd0,
    OFF_CONTROL = 3'd1,
    OFF_PER_L   = 3'd2,
    OFF_PER_H   = 3'd3,
    OFF_SNAP_L  = 3'd4,
    OFF_SNAP_H  = 3'd5,
    OFF_PENDING = 3'd6,
    OFF_RSVD    = 3'd7
  } reg_off_t;

  reg_off_t        off;
  logic [CH_AW:0]  ch_sel;
  logic            wr_en;

  assign off    = reg_off_t'(address[2:0]);
  assign ch_sel = (CH_AW+1)'(address >> 3);
  assign wr_en  = chipselect & ~write_n;

  // Shared prescaler; step marks the cycles on which running counters move.
  logic [PS_W-1:0] ps_cnt;
  logic            step;

  assign step = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  ps_cnt <= '0;
    else if (step) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

  logic [31:0]       per_ext  [NUM_CH];
  logic [31:0]       snap_ext [NUM_CH];
  logic [NUM_CH-1:0] run_v, to_v, cont_v, ito_v;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] period, counter, snap, per_wr;
    logic             run, to_flag, cont, ito, sel, timeout;

    assign sel     = wr_en & (ch_sel == (CH_AW+1)'(i));
    assign timeout = step & run & (counter == '0);

    // Full period after merging the written half into the stored one.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
      per_wr = period;
      if (off == OFF_PER_L) begin
        for (int b = 0; b < LO_W; b++) per_wr[b] = writedata[b];
      end else begin
        for (int b = 16; b < CNT_W; b++) per_wr[b] = writedata[b-16];
      end
    end

    // NOTE: non-blocking assignments; where several apply on one edge the later statement
    // wins, which is how the priority between timeout and register writes is expressed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        period  <= CNT_W'(DEF_PERIOD);
        counter <= CNT_W'(DEF_PERIOD);
        snap    <= '0;
        run     <= 1'b0;
        to_flag <= 1'b0;
        cont    <= 1'b0;
        ito     <= 1'b0;
      end else begin
        if (timeout)         counter <= period;
        else if (step & run) counter <= counter - CNT_W'(1);
        if (timeout & ~cont) run <= 1'b0;

        if (timeout)                          to_flag <= 1'b1;
        else if (sel && (off == OFF_STATUS))  to_flag <= 1'b0;

        if (sel) begin
          case (off)
            OFF_CONTROL: begin
              ito  <= writedata[0];
              cont <= writedata[1];
              if (writedata[2])      run <= 1'b1;
              else if (writedata[3]) run <= 1'b0;
            end
            OFF_PER_L, OFF_PER_H: begin
              period  <= per_wr;
              counter <= per_wr;
              run     <= 1'b0;
            end
            OFF_SNAP_L, OFF_SNAP_H: snap <= counter;
            default: ;
          endcase
        end
      end
    end

    assign per_ext[i]  = 32'(period);
    assign snap_ext[i] = 32'(snap);
    assign run_v[i]    = run;
    assign to_v[i]     = to_flag;
    assign cont_v[i]   = cont;
    assign ito_v[i]    = ito;
    assign tick[i]     = timeout;
    assign irq_vec[i]  = to_flag & ito;
  end

  assign irq = |irq_vec;

  // Read mux follows the address every cycle; chipselect only qualifies writes.
  logic [15:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == (CH_AW+1)'(i)) begin
        case (off)
          OFF_STATUS:  rd_next = {14'b0, run_v[i], to_v[i]};
          OFF_CONTROL: rd_next = {14'b0, cont_v[i], ito_v[i]};
          OFF_PER_L:   rd_next = per_ext[i][15:0];
          OFF_PER_H:   rd_next = per_ext[i][31:16];
          OFF_SNAP_L:  rd_next = snap_ext[i][15:0];
          OFF_SNAP_H:  rd_next = snap_ext[i][31:16];
          OFF_PENDING: rd_next = 16'(irq_vec);
          default:     rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_syn_timer_multi.sv
// Bench for syn_timer_multi: two builds (PRESCALE=1/CNT_W=32 and PRESCALE=4/CNT_W=12) on a
// shared bus, checked against hand-derived vectors and a per-cycle behavioural model.
module tb_syn_timer_multi;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] rd0, rd1;
  logic        irq0, irq1;
  logic [3:0]  iv0, iv1, tk0, tk1;

  always #5 clk = ~clk;

  syn_timer_multi #(.CH_AW(2), .CNT_W(32), .DEF_PERIOD(99), .PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .irq(irq0),
    .irq_vec(iv0), .tick(tk0));

  syn_timer_multi #(.CH_AW(2), .CNT_W(12), .DEF_PERIOD(99), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1),
    .irq_vec(iv1), .tick(tk1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: per instance, per channel register values advanced once per edge.
  int unsigned m_per [2][4];
  int unsigned m_cnt [2][4];
  int unsigned m_snap[2][4];
  bit          m_run [2][4];
  bit          m_to  [2][4];
  bit          m_cont[2][4];
  bit          m_ito [2][4];
  logic [15:0] m_rd  [2];
  int unsigned m_cyc;

  function automatic int unsigned ps_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int unsigned mask_of(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
  endfunction

  // The prescaler has counted m_cyc edges since reset; the next edge steps on its last value.
  function automatic bit m_step(int k);
    return (m_cyc % ps_of(k)) == ps_of(k) - 1;
  endfunction

  function automatic logic [3:0] m_pend(int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_to[k][c] & m_ito[k][c];
    return v;
  endfunction

  function automatic logic [3:0] m_tick(int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_run[k][c] && (m_cnt[k][c] == 0) && m_step(k);
    return v;
  endfunction

  function automatic logic [15:0] m_read(int k, logic [4:0] a);
    int ch;
    ch = int'(a[4:3]);
    case (a[2:0])
      3'd0:    return {14'b0, m_run[k][ch], m_to[k][ch]};
      3'd1:    return {14'b0, m_cont[k][ch], m_ito[k][ch]};
      3'd2:    return 16'(m_per[k][ch]);
      3'd3:    return 16'(m_per[k][ch] >> 16);
      3'd4:    return 16'(m_snap[k][ch]);
      3'd5:    return 16'(m_snap[k][ch] >> 16);
      3'd6:    return {12'b0, m_pend(k)};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        m_per[k][c] = 99; m_cnt[k][c] = 99; m_snap[k][c] = 0;
        m_run[k][c] = 0;  m_to[k][c] = 0;   m_cont[k][c] = 0; m_ito[k][c] = 0;
      end
      m_rd[k] = '0;
    end
    m_cyc = 0;
  endtask

  task automatic model_edge(input logic [4:0] a, input bit wr, input logic [15:0] wd);
    int          ch;
    bit          stp, tmo;
    int unsigned old_cnt;
    logic [15:0] rdv;
    ch = int'(a[4:3]);
    for (int k = 0; k < 2; k++) begin
      stp = m_step(k);
      rdv = m_read(k, a);
      for (int c = 0; c < 4; c++) begin
        old_cnt = m_cnt[k][c];
        tmo = m_run[k][c] && stp && (old_cnt == 0);
        if (tmo) begin
          m_to[k][c]  = 1;
          m_cnt[k][c] = m_per[k][c];
          if (!m_cont[k][c]) m_run[k][c] = 0;
        end else if (m_run[k][c] && stp) begin
          m_cnt[k][c] = old_cnt - 1;
        end
        if (wr && c == ch) begin
          case (a[2:0])
            3'd0: if (!tmo) m_to[k][c] = 0;
            3'd1: begin
              m_ito[k][c]  = wd[0];
              m_cont[k][c] = wd[1];
              if (wd[2])      m_run[k][c] = 1;
              else if (wd[3]) m_run[k][c] = 0;
            end
            3'd2, 3'd3: begin
              if (a[0]) m_per[k][c] = ((m_per[k][c] & 32'h0000_FFFF) | (32'(wd) << 16)) & mask_of(k);
              else      m_per[k][c] = ((m_per[k][c] & 32'hFFFF_0000) | 32'(wd)) & mask_of(k);
              m_cnt[k][c] = m_per[k][c];
              m_run[k][c] = 0;
            end
            3'd4, 3'd5: m_snap[k][c] = old_cnt;
            default: ;
          endcase
        end
      end
      m_rd[k] = rdv;
    end
    m_cyc++;
  endtask

  task automatic compare_all();
    check("inst0_readdata", 32'(rd0), 32'(m_rd[0]));
    check("inst1_readdata", 32'(rd1), 32'(m_rd[1]));
    check("inst0_irq_vec",  32'(iv0), 32'(m_pend(0)));
    check("inst1_irq_vec",  32'(iv1), 32'(m_pend(1)));
    check("inst0_irq",      32'(irq0), 32'(|m_pend(0)));
    check("inst1_irq",      32'(irq1), 32'(|m_pend(1)));
    check("inst0_tick",     32'(tk0), 32'(m_tick(0)));
    check("inst1_tick",     32'(tk1), 32'(m_tick(1)));
  endtask

  // One bus cycle: drive at a falling edge, let the rising edge act, compare at the next fall.
  task automatic cycle(input logic [4:0] a, input bit wr, input logic [15:0] wd);
    address    = a;
    chipselect = wr ? 1'b1 : 1'($urandom_range(0, 1));
    write_n    = wr ? 1'b0 : (chipselect ? 1'b1 : 1'($urandom_range(0, 1)));
    writedata  = wr ? wd : 16'($urandom);
    model_edge(a, wr, wd);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    cycle(a, 1'b1, d);
  endtask

  task automatic rd(input logic [4:0] a);
    cycle(a, 1'b0, 16'h0);
  endtask

  task automatic idle();
    cycle(5'($urandom), 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  typedef struct {
    logic [4:0]  addr;
    bit          wr;
    logic [15:0] wd;
    bit          chk;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t vecs[$];
  int   q0[$];
  int   q1[$];
  bit   found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // PRESCALE=4 build: period 2 continuous on ch0 gives a tick every 12 cycles.
    wr(5'h02, 16'd2); wr(5'h03, 16'd0); wr(5'h01, 16'h0006);
    for (int i = 0; i < 40; i++) begin
      idle();
      if (tk0[0]) q0.push_back(i);
      if (tk1[0]) q1.push_back(i);
    end
    check("p4_tick_count", 32'(q1.size() >= 3), 1);
    for (int j = 1; j < q1.size(); j++) check("p4_tick_spacing", q1[j] - q1[j-1], 12);
    check("p1_tick_count", 32'(q0.size() >= 10), 1);
    for (int j = 1; j < q0.size(); j++) check("p1_tick_spacing", q0[j] - q0[j-1], 3);
    for (int c = 1; c < 4; c++) begin
      wr({2'(c), 3'd4}, 16'h0);
      rd({2'(c), 3'd4});
      check("untouched_counter", 32'(rd1), 32'h63);
      rd({2'(c), 3'd0});
      check("untouched_status", 32'(rd1), 32'h0);
    end

    do_reset();
    check("reset_irq", 32'(irq0), 0);
    vecs.push_back('{5'h02, 1'b0, 16'h0000, 1'b1, 16'h0063, 16'h0063});
    vecs.push_back('{5'h03, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h00, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h01, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h06, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h07, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h07, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h16, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h16, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h1B, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h1B, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0000});
    vecs.push_back('{5'h1A, 1'b1, 16'hABCD, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h1A, 1'b0, 16'h0000, 1'b1, 16'hABCD, 16'h0BCD});
    vecs.push_back('{5'h19, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h19, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0003});
    vecs.push_back('{5'h19, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000});
    vecs.push_back('{5'h19, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    vecs.push_back('{5'h1C, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000});
    foreach (vecs[v]) begin
      cycle(vecs[v].addr, vecs[v].wr, vecs[v].wd);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d_inst0", v), 32'(rd0), 32'(vecs[v].e0));
        check($sformatf("vec%0d_inst1", v), 32'(rd1), 32'(vecs[v].e1));
      end
    end

    // Ch1 period 5 continuous with interrupt: ticks 6 cycles apart, status write clears irq.
    do_reset();
    wr(5'h0A, 16'd5); wr(5'h0B, 16'd0); wr(5'h09, 16'h0007);
    q0.delete();
    for (int i = 0; i < 14; i++) begin
      idle();
      if (tk0[1]) q0.push_back(i);
    end
    check("ch1_tick_count", q0.size(), 2);
    if (q0.size() == 2) begin
      check("ch1_first_tick", q0[0], 4);
      check("ch1_second_tick", q0[1], 10);
    end
    check("ch1_irq_vec", 32'(iv0), 32'h2);
    check("ch1_irq", 32'(irq0), 1);
    wr(5'h08, 16'h0);
    check("ch1_irq_cleared", 32'(irq0), 0);
    wr(5'h09, 16'h0008);

    // Ch2 one-shot period 3: one tick, then status shows to=1 run=0 and counter reloaded.
    wr(5'h12, 16'd3); wr(5'h13, 16'd0); wr(5'h11, 16'h0004);
    q0.delete();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (tk0[2]) q0.push_back(i);
    end
    check("ch2_tick_count", q0.size(), 1);
    if (q0.size() == 1) check("ch2_tick_time", q0[0], 2);
    rd(5'h10);
    check("ch2_status", 32'(rd0), 32'h0001);
    wr(5'h14, 16'h0);
    rd(5'h14);
    check("ch2_reloaded", 32'(rd0), 32'h0003);

    // Ch0 period 0x1_0000: snapshot after 10 counting cycles.
    wr(5'h02, 16'h0000); wr(5'h03, 16'h0001); wr(5'h01, 16'h0004);
    for (int i = 0; i < 10; i++) idle();
    wr(5'h04, 16'h0);
    rd(5'h04);
    check("ch0_snap_l", 32'(rd0), 32'hFFF6);
    rd(5'h05);
    check("ch0_snap_h", 32'(rd0), 32'h0000);
    wr(5'h01, 16'h0008);

    // Ch3 continuous: status clear on the timeout edge loses; start+stop starts.
    wr(5'h1A, 16'd3); wr(5'h1B, 16'd0); wr(5'h19, 16'h0006);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin idle(); found = tk0[3]; end
    check("ch3_tick_seen", 32'(found), 1);
    idle();
    wr(5'h18, 16'h0);
    rd(5'h18);
    check("ch3_status_cleared", 32'(rd0), 32'h0002);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin idle(); found = tk0[3]; end
    check("ch3_tick_seen_again", 32'(found), 1);
    wr(5'h18, 16'h0);
    rd(5'h18);
    check("ch3_set_wins", 32'(rd0), 32'h0003);
    wr(5'h19, 16'h0008);
    rd(5'h18);
    check("ch3_stopped", 32'(rd0), 32'h0001);
    wr(5'h19, 16'h000C);
    rd(5'h18);
    check("ch3_start_wins", 32'(rd0), 32'h0003);
    wr(5'h19, 16'h0008);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  ch;
      logic [2:0]  off;
      logic [15:0] d;
      ch  = 2'($urandom_range(0, 3));
      off = 3'($urandom_range(0, 7));
      case (off)
        3'd1:    d = 16'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 16'h4 : 16'h0);
        3'd2:    d = 16'($urandom_range(0, 7));
        3'd3:    d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
        default: d = 16'($urandom);
      endcase
      cycle({ch, off}, $urandom_range(0, 2) == 0, d);
    end

    // Asynchronous reset while an interrupt is pending.
    do_reset();
    wr(5'h0A, 16'd1); wr(5'h0B, 16'd0); wr(5'h09, 16'h0007);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin idle(); found = irq0; end
    check("pre_reset_irq", 32'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq0), 0);
    check("async_reset_irq_vec", 32'(iv0), 0);
    check("async_reset_tick", 32'(tk0), 0);
    check("async_reset_readdata", 32'(rd0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    compare_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_timer_multi.md
Name: syn_timer_multi

Overview:
Parametrised multi-channel Avalon-MM interval timer, successor to the fixed-period single-channel 1 us timer in limbus_sys.
Provides 2**CH_AW independent down-counters, each CNT_W bits wide, with software-programmable period, one-shot/continuous mode, snapshot and per-channel interrupt.
All channels share one slave port, one prescaler and one combined irq line, plus a per-channel tick vector for direct hardware use.

Parameters:
CH_AW, 2, channel address bits; NUM_CH = 2**CH_AW channels (legal 0..3).
CNT_W, 32, counter/period width (legal 2..32).
DEF_PERIOD, 99, period and counter reset value for every channel (must fit CNT_W).
PRESCALE, 1, clk cycles per counter decrement (legal 1..65536); 1 = every cycle.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
address  in  CH_AW+3  [CH_AW+2:3] channel, [2:0] register offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  16  write data
readdata  out  16  registered read data
irq  out  1  OR of all channel interrupts
irq_vec  out  NUM_CH  per-channel interrupt
tick  out  NUM_CH  1-cycle pulse per channel timeout

Behaviour:
- Reset (async, reset_n=0): period=counter=DEF_PERIOD, run=0, to=0, cont=0, ito=0, snapshot=0, prescaler=0, readdata=0, irq=0, irq_vec=0, tick=0.
- Write = chipselect & ~write_n; applies on that clk edge to the addressed channel only.
- Register map (per-channel offset):
  - 0 status: read {14'b0, run, to}; any write clears to.
  - 1 control: read {14'b0, cont, ito}; write bit0=ito, bit1=cont stored; bit2=start, bit3=stop are strobes, read 0.
  - 2 period_l, 3 period_h: 16-bit halves of period; bits >= CNT_W ignored, read as 0.
  - 4 snap_l, 5 snap_h: read latched snapshot halves; a write to either latches the channel's current counter.
  - 6 pending: read {zero-pad, irq_vec}, same from any channel; writes ignored.
  - 7: reserved, reads 0, writes ignored.
- Read latency: exactly 1 cycle. readdata is updated every clk edge from the current address, regardless of chipselect.
- Prescaler: free-running 0..PRESCALE-1 counter, never reset except by reset_n. The step enable is asserted when it equals PRESCALE-1; for PRESCALE=1 it is always asserted. The first decrement after start has up to PRESCALE-1 cycles of jitter.
- Counting (per channel, on step while run=1):
  - counter!=0: counter <= counter-1.
  - counter==0: timeout. tick pulses high for that clk cycle, to <= 1, and counter <= period.
  - Continuous (cont=1): run stays 1. One-shot (cont=0): run <= 0.
  - Period P therefore gives a timeout every (P+1)*PRESCALE cycles. P=0 with cont=1 gives a timeout every step.
- Period write: on the write edge the period half is updated, counter <= the new full period value (other half unchanged), and run <= 0. The counter does not restart until start is written.
- Start: run <= 1; the counter continues from its current value (no reload).
- Stop: run <= 0; the counter holds its value.
- Simultaneous events (priority rules):
  - start and stop in one write: start wins.
  - stop write coincident with a timeout: run <= 0 and the counter is reloaded; to is still set and tick still pulses.
  - status-clear write coincident with a timeout on the same channel: the set wins, to=1.
  - snapshot write coincident with a decrement: the pre-decrement value is captured.
- Interrupts: irq_vec[i] = to[i] & ito[i], combinational from registers. irq = |irq_vec. Clearing ito masks the interrupt without clearing to.
- Channels are fully independent; accesses to channel i never alter channel j state.
- Reset mid-count: immediate return to reset values; tick and irq drop asynchronously.

Test Plan:
- Reset, read ch0 period_l/period_h/status -> 0x0063/0x0000/0x0000 one cycle after each read; irq=0.
- Ch1 period=5, control=0x0007 (start, cont, ito), PRESCALE=1 -> tick[1] every 6 cycles, irq_vec=4'b0010, irq=1; write status -> irq=0 until next tick.
- Ch2 period=3, control=0x0004 (one-shot) -> single tick[2] 4 cycles after start; status then reads 0x0001 (run=0, to=1), counter reloaded to 3.
- Ch0 period=0x0001_0000 (CNT_W=32), start, then after 10 cycles write snap_l -> snap_l=0xFFF6 (or prescale-equivalent), snap_h=0x0000.
- Ch3 continuous running: write status on the exact timeout cycle -> to remains 1; write control=0x000C (start+stop) -> run=1.
- PRESCALE=4 build, ch0 period=2 continuous -> tick[0] every 12 cycles; channels 1-3 untouched remain run=0, counter=0x63.
